// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, excepttype codes, field positions and
// the helpers that classify an incoming excepttype code.
package cp0_defs;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   localparam logic [31:0] EXCTYPE_NONE = 32'h0000_0000;
   localparam logic [31:0] EXCTYPE_INT  = 32'h0000_0001;
   localparam logic [31:0] EXCTYPE_ADEL = 32'h0000_0004;
   localparam logic [31:0] EXCTYPE_ADES = 32'h0000_0005;
   localparam logic [31:0] EXCTYPE_SYS  = 32'h0000_0008;
   localparam logic [31:0] EXCTYPE_BP   = 32'h0000_0009;
   localparam logic [31:0] EXCTYPE_RI   = 32'h0000_000A;
   localparam logic [31:0] EXCTYPE_OV   = 32'h0000_000C;
   localparam logic [31:0] EXCTYPE_ERET = 32'h0000_000E;

   localparam logic [4:0] EXCCODE_INT = 5'h00;

   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;
   localparam int CAUSE_BD   = 31;

   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

   localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'hBFC0_0380;
   localparam logic [31:0] DEFAULT_STATUS_RESET = 32'h0040_0000;

   // Codes that commit EPC/Cause/Status; eret and unknown codes only flush.
   function automatic logic is_exception(input logic [31:0] code);
      case (code)
         EXCTYPE_INT, EXCTYPE_ADEL, EXCTYPE_ADES, EXCTYPE_SYS,
         EXCTYPE_BP, EXCTYPE_RI, EXCTYPE_OV: is_exception = 1'b1;
         default:                            is_exception = 1'b0;
      endcase
   endfunction

   function automatic logic [4:0] exc_code(input logic [31:0] code);
      exc_code = (code == EXCTYPE_INT) ? EXCCODE_INT : code[4:0];
   endfunction

endpackage

// File: rtl/cp0_exception_unit_timer.sv
// Count/Compare timer: Count advances on every other clock, and the timer interrupt
// stays asserted until software rewrites Compare.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_int
);

   logic tick;

   always_ff @(posedge clk) begin
      if (rst) tick <= 1'b0;
      else     tick <= ~tick;
   end

   // A software load of Count leaves the tick phase untouched.
   always_ff @(posedge clk) begin
      if (rst)           count <= 32'h0;
      else if (count_we) count <= wdata;
      else if (tick)     count <= count + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)             compare <= 32'h0;
      else if (compare_we) compare <= wdata;
   end

   // Compare==0 is treated as "timer disabled"; a Compare write beats a same-cycle match.
   always_ff @(posedge clk) begin
      if (rst)                                        timer_int <= 1'b0;
      else if (compare_we)                            timer_int <= 1'b0;
      else if (compare != 32'h0 && count == compare)  timer_int <= 1'b1;
   end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file and exception commit at the MEM/WB boundary: records EPC/Cause/
// Status/BadVAddr, flushes the pipeline and supplies the redirect PC.
module cp0_exception_unit
   import cp0_defs::*;
#(
   parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR,
   parameter logic [31:0] STATUS_RESET = DEFAULT_STATUS_RESET
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  raddr_i,
   output logic [31:0] data_o,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] pc_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   logic exc_commit;
   logic is_eret;
   logic mtc0_ok;

   assign flush_o    = (excepttype_i != EXCTYPE_NONE);
   assign exc_commit = is_exception(excepttype_i);
   assign is_eret    = (excepttype_i == EXCTYPE_ERET);
   // An MTC0 that shares its cycle with any flush belongs to a killed instruction.
   assign mtc0_ok    = we_i && !flush_o;

   always_comb begin
      new_pc_o = EXC_VECTOR;
      if (is_eret) new_pc_o = (we_i && waddr_i == REG_EPC) ? data_i : epc_o;
   end

   cp0_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .count_we   (mtc0_ok && waddr_i == REG_COUNT),
      .compare_we (mtc0_ok && waddr_i == REG_COMPARE),
      .wdata      (data_i),
      .count      (count_o),
      .compare    (compare_o),
      .timer_int  (timer_int_o)
   );

   always_ff @(posedge clk) begin
      if (rst)                                  status_o <= STATUS_RESET;
      else if (exc_commit)                      status_o[STATUS_EXL] <= 1'b1;
      else if (is_eret)                         status_o[STATUS_EXL] <= 1'b0;
      else if (mtc0_ok && waddr_i == REG_STATUS)
         status_o <= (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
   end

   // IP[15:10] mirror the interrupt lines every cycle, with the timer folded into IP[15].
   always_ff @(posedge clk) begin
      if (rst) begin
         cause_o <= 32'h0;
      end else begin
         cause_o[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};
         if (exc_commit) begin
            if (!status_o[STATUS_EXL]) cause_o[CAUSE_BD] <= in_delayslot_i;
            cause_o[6:2] <= exc_code(excepttype_i);
         end else if (mtc0_ok && waddr_i == REG_CAUSE) begin
            cause_o[9:8] <= data_i[9:8];
         end
      end
   end

   // Nested exceptions (EXL already set) keep the original return address.
   always_ff @(posedge clk) begin
      if (rst)                                   epc_o <= 32'h0;
      else if (exc_commit && !status_o[STATUS_EXL])
         epc_o <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
      else if (mtc0_ok && waddr_i == REG_EPC)    epc_o <= data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) badvaddr_o <= 32'h0;
      else if (excepttype_i == EXCTYPE_ADEL || excepttype_i == EXCTYPE_ADES)
         badvaddr_o <= bad_addr_i;
      else if (mtc0_ok && waddr_i == REG_BADVADDR) badvaddr_o <= data_i;
   end

   always_comb begin
      data_o = 32'h0;
      case (raddr_i)
         REG_BADVADDR: data_o = badvaddr_o;
         REG_COUNT:    data_o = count_o;
         REG_COMPARE:  data_o = compare_o;
         REG_STATUS:   data_o = status_o;
         REG_CAUSE:    data_o = cause_o;
         REG_EPC:      data_o = epc_o;
         default:      data_o = 32'h0;
      endcase
   end

endmodule
